// File: rtl/soc_system_tc_mem_pkg.sv
// Shared types, limits and the per-lane merge helper for the tightly-coupled memory.
package soc_system_tc_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_INIT  = 2'd2
    } tcm_state_t;

    localparam int TCM_DATA_WIDTH = 32;
    localparam int BE_WIDTH       = TCM_DATA_WIDTH / 8;
    localparam int MIN_RD_LAT     = 1;
    localparam int MAX_RD_LAT     = 3;

    function automatic logic [7:0] lane_merge(input logic [7:0] old_b,
                                              input logic [7:0] new_b,
                                              input logic       en);
        return en ? new_b : old_b;
    endfunction

endpackage

// File: rtl/soc_system_tc_mem_rd_pipe.sv
// Read-return pipeline: LATENCY-deep valid/data shift register; the last data stage
// only loads on a valid beat so the port's readdata holds between returns.
module soc_system_tc_mem_rd_pipe
    import soc_system_tc_mem_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    localparam int LAT = (LATENCY < MIN_RD_LAT) ? MIN_RD_LAT :
                         (LATENCY > MAX_RD_LAT) ? MAX_RD_LAT : LATENCY;

    logic [LAT-1:0]   r_vld;
    logic [WIDTH-1:0] r_dat [LAT];
    logic [LAT-1:0]   w_vin;
    logic [WIDTH-1:0] w_din [LAT];

    always_comb begin
        w_vin    = '0;
        w_vin[0] = i_valid;
        w_din[0] = i_data;
        for (int k = 1; k < LAT; k++) begin
            w_vin[k] = r_vld[k-1];
            w_din[k] = r_dat[k-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
            for (int k = 0; k < LAT; k++) r_dat[k] <= '0;
        end else begin
            for (int k = 0; k < LAT; k++) begin
                r_vld[k] <= w_vin[k];
                if (w_vin[k]) r_dat[k] <= w_din[k];
            end
        end
    end

    assign o_valid = r_vld[LAT-1];
    assign o_data  = r_dat[LAT-1];

endmodule

// File: rtl/soc_system_tc_mem_pipe.sv
// Dual-port scratch RAM behind two Avalon-MM pipelined slaves; s1 adds read bursts.
// Define SOC_SYSTEM_TC_MEM_SCRUB_EN to zero the whole array after every reset.
module soc_system_tc_mem_pipe
    import soc_system_tc_mem_pkg::*;
#(
    parameter int DATA_WIDTH   = TCM_DATA_WIDTH,
    parameter int DEPTH        = 6144,
    parameter int ADDR_WIDTH   = 13,
    parameter int READ_LATENCY = 2,
    parameter int MAX_BURST    = 8,
    parameter int BURST_WIDTH  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH/8-1:0] byteenable,
    input  logic                    chipselect,
    input  logic                    read,
    input  logic                    write,
    input  logic [DATA_WIDTH-1:0]   writedata,
    input  logic [BURST_WIDTH-1:0]  burstcount,
    output logic [DATA_WIDTH-1:0]   readdata,
    output logic                    readdatavalid,
    output logic                    waitrequest,
    input  logic [ADDR_WIDTH-1:0]   address2,
    input  logic [DATA_WIDTH/8-1:0] byteenable2,
    input  logic                    chipselect2,
    input  logic                    read2,
    input  logic                    write2,
    input  logic [DATA_WIDTH-1:0]   writedata2,
    output logic [DATA_WIDTH-1:0]   readdata2,
    output logic                    readdatavalid2,
    output logic                    waitrequest2,
    output logic                    init_done
);

    localparam int BEW = DATA_WIDTH / 8;
`ifdef SOC_SYSTEM_TC_MEM_SCRUB_EN
    localparam tcm_state_t RESET_STATE = ST_INIT;
`else
    localparam tcm_state_t RESET_STATE = ST_IDLE;
`endif

    tcm_state_t              r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_burst_addr, w_rd_addr1;
    logic [BURST_WIDTH-1:0]  r_burst_rem, w_blen;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
    logic                    w_acc1, w_acc2, w_wr1, w_wr2, w_rd1, w_rd2;
    logic                    w_issue1, w_burst_start;
    logic [DATA_WIDTH-1:0]   w_rdata1, w_fwd2, w_wword1;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return 32'(a) < DEPTH;
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
        return (a == ADDR_WIDTH'(DEPTH - 1)) ? '0 : a + 1'b1;
    endfunction

    // Word at address a as it will read after this cycle's writes; s1 lanes win over s2.
    function automatic logic [DATA_WIDTH-1:0] fwd(input logic [ADDR_WIDTH-1:0] a);
        logic [DATA_WIDTH-1:0] w;
        logic                  hit1, hit2;
        w    = in_range(a) ? r_mem[a] : '0;
        hit1 = w_wr1 && (address == a);
        hit2 = w_wr2 && (address2 == a);
        for (int l = 0; l < BEW; l++) begin
            w[l*8 +: 8] = lane_merge(w[l*8 +: 8], writedata2[l*8 +: 8], hit2 & byteenable2[l]);
            w[l*8 +: 8] = lane_merge(w[l*8 +: 8], writedata[l*8 +: 8], hit1 & byteenable[l]);
        end
        return w;
    endfunction

    assign w_acc1        = chipselect & (read | write) & ~waitrequest;
    assign w_acc2        = chipselect2 & (read2 | write2) & ~waitrequest2;
    assign w_wr1         = w_acc1 & write & in_range(address);
    assign w_wr2         = w_acc2 & write2 & in_range(address2);
    assign w_rd1         = w_acc1 & read & ~write;
    assign w_rd2         = w_acc2 & read2 & ~write2;
    assign w_blen        = (burstcount > BURST_WIDTH'(MAX_BURST)) ? BURST_WIDTH'(MAX_BURST) : burstcount;
    assign w_burst_start = (r_state == ST_IDLE) & w_rd1 & (w_blen > BURST_WIDTH'(1));
    assign w_issue1      = ((r_state == ST_IDLE) & w_rd1) | (r_state == ST_BURST);
    assign w_rd_addr1    = (r_state == ST_BURST) ? r_burst_addr : address;
    assign w_rdata1      = fwd(w_rd_addr1);
    assign w_fwd2        = fwd(address2);
    assign w_wword1      = fwd(address);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= RESET_STATE;
        else       r_state <= w_state_nxt;
    end

`ifdef SOC_SYSTEM_TC_MEM_SCRUB_EN
    logic [ADDR_WIDTH-1:0] r_init_addr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                  r_init_addr <= '0;
        else if (r_state == ST_INIT) r_init_addr <= r_init_addr + 1'b1;
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_burst_start) w_state_nxt = ST_BURST;
            ST_BURST: if (r_burst_rem == BURST_WIDTH'(1)) w_state_nxt = ST_IDLE;
`ifdef SOC_SYSTEM_TC_MEM_SCRUB_EN
            ST_INIT:  if (r_init_addr == ADDR_WIDTH'(DEPTH - 1)) w_state_nxt = ST_IDLE;
`endif
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        waitrequest  = (r_state != ST_IDLE);
        waitrequest2 = (r_state == ST_INIT);
    end

`ifdef SOC_SYSTEM_TC_MEM_SCRUB_EN
    assign init_done = (r_state != ST_INIT);
`else
    assign init_done = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_burst_addr <= '0;
            r_burst_rem  <= '0;
        end else if (w_burst_start) begin
            r_burst_addr <= next_addr(address);
            r_burst_rem  <= w_blen - 1'b1;
        end else if (r_state == ST_BURST) begin
            r_burst_addr <= next_addr(r_burst_addr);
            r_burst_rem  <= r_burst_rem - 1'b1;
        end
    end

    // Array has no reset so contents survive it; on collision the s1 word already carries s2 lanes.
    always_ff @(posedge clk) begin
`ifdef SOC_SYSTEM_TC_MEM_SCRUB_EN
        if (r_state == ST_INIT) r_mem[r_init_addr] <= '0;
`endif
        if (w_wr2) r_mem[address2] <= w_fwd2;
        if (w_wr1) r_mem[address]  <= w_wword1;
    end

    soc_system_tc_mem_rd_pipe #(.WIDTH(DATA_WIDTH), .LATENCY(READ_LATENCY)) u_rd1 (
        .clk     (clk),
        .rst     (reset),
        .i_valid (w_issue1),
        .i_data  (w_rdata1),
        .o_valid (readdatavalid),
        .o_data  (readdata)
    );

    soc_system_tc_mem_rd_pipe #(.WIDTH(DATA_WIDTH), .LATENCY(READ_LATENCY)) u_rd2 (
        .clk     (clk),
        .rst     (reset),
        .i_valid (w_rd2),
        .i_data  (w_fwd2),
        .o_valid (readdatavalid2),
        .o_data  (readdata2)
    );

endmodule

// File: tb/tb_soc_system_tc_mem_pipe.sv
// Directed bench for soc_system_tc_mem_pipe at default parameters (scrub disabled).
module tb_soc_system_tc_mem_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic [12:0] address, address2;
    logic [3:0]  byteenable, byteenable2, burstcount;
    logic        chipselect, read, write, chipselect2, read2, write2;
    logic [31:0] writedata, writedata2, readdata, readdata2;
    logic        readdatavalid, readdatavalid2, waitrequest, waitrequest2, init_done;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    soc_system_tc_mem_pipe dut (
        .clk            (clk),
        .reset          (reset),
        .address        (address),
        .byteenable     (byteenable),
        .chipselect     (chipselect),
        .read           (read),
        .write          (write),
        .writedata      (writedata),
        .burstcount     (burstcount),
        .readdata       (readdata),
        .readdatavalid  (readdatavalid),
        .waitrequest    (waitrequest),
        .address2       (address2),
        .byteenable2    (byteenable2),
        .chipselect2    (chipselect2),
        .read2          (read2),
        .write2         (write2),
        .writedata2     (writedata2),
        .readdata2      (readdata2),
        .readdatavalid2 (readdatavalid2),
        .waitrequest2   (waitrequest2),
        .init_done      (init_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        chipselect = 0; read = 0; write = 0; address = '0; writedata = '0; byteenable = '0;
        burstcount = '0;
        chipselect2 = 0; read2 = 0; write2 = 0; address2 = '0; writedata2 = '0; byteenable2 = '0;
    endtask

    task automatic wr1(input logic [12:0] a, input logic [31:0] d, input logic [3:0] be);
        chipselect = 1; write = 1; address = a; writedata = d; byteenable = be;
        tick();
        idle();
    endtask

    task automatic rd(input string tag, input int port, input logic [12:0] a, input logic [31:0] exp);
        if (port == 1) begin
            chipselect = 1; read = 1; address = a; burstcount = 4'd1;
        end else begin
            chipselect2 = 1; read2 = 1; address2 = a;
        end
        tick();
        idle();
        chk({tag, "_vld_lat1"}, (port == 1) ? readdatavalid : readdatavalid2, 0);
        tick();
        chk({tag, "_vld_lat2"}, (port == 1) ? readdatavalid : readdatavalid2, 1);
        chk({tag, "_data"}, (port == 1) ? readdata : readdata2, exp);
        tick();
        chk({tag, "_vld_after"}, (port == 1) ? readdatavalid : readdatavalid2, 0);
        chk({tag, "_hold"}, (port == 1) ? readdata : readdata2, exp);
    endtask

    initial begin
        logic [5:0]  wexp;
        logic [5:0]  vexp;
        logic [31:0] dexp [6];
        int          nw, nv;

        idle();
        reset = 1;
        repeat (3) tick();
        chk("rst_readdata", readdata, 0);
        chk("rst_readdatavalid", readdatavalid, 0);
        chk("rst_waitrequest", waitrequest, 0);
        chk("rst_readdata2", readdata2, 0);
        chk("rst_readdatavalid2", readdatavalid2, 0);
        chk("rst_waitrequest2", waitrequest2, 0);
        chk("rst_init_done", init_done, 1);
        reset = 0;
        tick();

        wr1(13'd5, 32'hDEADBEEF, 4'hF);
        rd("rd5", 1, 13'd5, 32'hDEADBEEF);

        wr1(13'd9, 32'hAABBCCDD, 4'hF);
        wr1(13'd9, 32'h11223344, 4'h5);
        rd("lane9", 2, 13'd9, 32'hAA22CC44);

        // both ports write address 7 in the same cycle
        chipselect = 1; write = 1; address = 13'd7; writedata = 32'h11111111; byteenable = 4'h3;
        chipselect2 = 1; write2 = 1; address2 = 13'd7; writedata2 = 32'h22222222; byteenable2 = 4'hE;
        tick();
        idle();
        rd("coll7_s1", 1, 13'd7, 32'h22221111);
        rd("coll7_s2", 2, 13'd7, 32'h22221111);

        // s2 reads the word s1 writes in the same cycle
        wr1(13'd20, 32'h0, 4'hF);
        chipselect = 1; write = 1; address = 13'd20; writedata = 32'h12345678; byteenable = 4'hF;
        chipselect2 = 1; read2 = 1; address2 = 13'd20;
        tick();
        idle();
        chk("fwd20_vld_lat1", readdatavalid2, 0);
        tick();
        chk("fwd20_vld_lat2", readdatavalid2, 1);
        chk("fwd20_data", readdata2, 32'h12345678);

        // s1 reads while s2 writes one lane of the same word
        wr1(13'd21, 32'hCAFEF00D, 4'hF);
        chipselect2 = 1; write2 = 1; address2 = 13'd21; writedata2 = 32'h000000AB; byteenable2 = 4'h1;
        chipselect = 1; read = 1; address = 13'd21; burstcount = 4'd1;
        tick();
        idle();
        tick();
        chk("fwd21_vld", readdatavalid, 1);
        chk("fwd21_data", readdata, 32'hCAFEF0AB);

        // read and write together: write wins, no read return
        chipselect = 1; read = 1; write = 1; address = 13'd30; writedata = 32'h30303030; byteenable = 4'hF;
        burstcount = 4'd1;
        tick();
        idle();
        chk("rw30_no_vld1", readdatavalid, 0);
        tick();
        chk("rw30_no_vld2", readdatavalid, 0);
        rd("rw30", 1, 13'd30, 32'h30303030);

        // burst across the top of the array
        wr1(13'd6142, 32'hA0A0A0A0, 4'hF);
        wr1(13'd6143, 32'hA1A1A1A1, 4'hF);
        wr1(13'd0, 32'hA2A2A2A2, 4'hF);
        wr1(13'd1, 32'hA3A3A3A3, 4'hF);
        wexp = 6'b000111;
        vexp = 6'b011110;
        dexp = '{32'h0, 32'hA0A0A0A0, 32'hA1A1A1A1, 32'hA2A2A2A2, 32'hA3A3A3A3, 32'h0};
        chipselect = 1; read = 1; address = 13'd6142; burstcount = 4'd4;
        tick();
        idle();
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("burst_wait_%0d", k), waitrequest, wexp[k]);
            chk($sformatf("burst_wait2_%0d", k), waitrequest2, 0);
            chk($sformatf("burst_vld_%0d", k), readdatavalid, vexp[k]);
            if (vexp[k]) chk($sformatf("burst_data_%0d", k), readdata, dexp[k]);
            tick();
        end

        // oversize burstcount clamps to 8 beats
        chipselect = 1; read = 1; address = 13'h100; burstcount = 4'd15;
        tick();
        idle();
        nw = 0; nv = 0;
        for (int k = 0; k < 14; k++) begin
            nw += waitrequest;
            nv += readdatavalid;
            tick();
        end
        chk("clamp_wait_cycles", nw, 7);
        chk("clamp_beats", nv, 8);

        // burstcount 0 is a single beat
        chipselect = 1; read = 1; address = 13'd5; burstcount = 4'd0;
        tick();
        idle();
        nw = 0; nv = 0;
        for (int k = 0; k < 4; k++) begin
            nw += waitrequest;
            nv += readdatavalid;
            tick();
        end
        chk("bc0_wait_cycles", nw, 0);
        chk("bc0_beats", nv, 1);

        // reset two beats into a burst
        chipselect = 1; read = 1; address = 13'd6142; burstcount = 4'd4;
        tick();
        idle();
        tick();
        chk("pre_rst_vld", readdatavalid, 1);
        reset = 1;
        #1;
        chk("mid_rst_readdata", readdata, 0);
        chk("mid_rst_vld", readdatavalid, 0);
        chk("mid_rst_wait", waitrequest, 0);
        tick();
        tick();
        reset = 0;
        nv = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            nv += readdatavalid;
        end
        chk("post_rst_no_vld", nv, 0);
        rd("post_rst_6142", 1, 13'd6142, 32'hA0A0A0A0);
        rd("post_rst_1", 2, 13'd1, 32'hA3A3A3A3);

        // out of range
        wr1(13'd56, 32'h56565656, 4'hF);
        wr1(13'd2104, 32'h21042104, 4'hF);
        wr1(13'd6200, 32'hFFFFFFFF, 4'hF);
        rd("oor_s1", 1, 13'd6200, 32'h0);
        rd("oor_s2", 2, 13'd6200, 32'h0);
        rd("oor_keep56", 1, 13'd56, 32'h56565656);
        rd("oor_keep2104", 2, 13'd2104, 32'h21042104);
        rd("oor_keep5", 1, 13'd5, 32'hDEADBEEF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
